// File: rtl/sdram_bank_client.sv
// SDRAM bank client: turns one client read (32-bit burst) or write (16-bit word)
// into a controller bank-port transaction, ending with a one-cycle response.
module sdram_bank_client #(
  parameter int         TIMEOUT  = 511,
  parameter logic [1:0] BANK_SEL = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_rdy_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [23:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic [1:0]  cmd_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rden,
  output logic        wren,
  output logic [31:0] addr,
  input  logic        valid,
  input  logic        fetch,
  output logic [1:0]  wr_bena,
  output logic [15:0] wr_data,
  input  logic [15:0] rd_data
);

  localparam logic [10:0] TIMEOUT_L = 11'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_W1, WR_REQ, WR_P1, WR_P2, RESP
  } state_t;

  state_t      state_reg, state_next;
  logic [9:0]  cnt_reg, cnt_next;
  logic        rden_reg, rden_next;
  logic        wren_reg, wren_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [15:0] wr_data_reg, wr_data_next;
  logic [1:0]  wr_bena_reg, wr_bena_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;

  logic       accept;
  logic [9:0] cnt_inc;
  logic       timeout_hit;

  assign cmd_ready = (state_reg == IDLE) && !ram_rdy_n;
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_inc   = (cnt_reg == 10'h3FF) ? cnt_reg : cnt_reg + 10'd1;
  // True when this waiting cycle brings the counter up to TIMEOUT.
  assign timeout_hit = ({1'b0, cnt_reg} + 11'd1) >= TIMEOUT_L;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rden_next      = rden_reg;
    wren_next      = wren_reg;
    addr_next      = addr_reg;
    rdata_next     = rdata_reg;
    wr_data_next   = wr_data_reg;
    wr_bena_next   = wr_bena_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next = 10'd0;
          if (cmd_we) begin
            state_next   = WR_REQ;
            wren_next    = 1'b1;
            addr_next    = {6'b0, BANK_SEL, cmd_addr[23:1], 1'b0};
            wr_data_next = cmd_wdata;
            wr_bena_next = cmd_be;
          end else begin
            state_next   = RD_REQ;
            rden_next    = 1'b1;
            addr_next    = {6'b0, BANK_SEL, cmd_addr[23:2], 2'b00};
          end
        end
      end
      RD_REQ: begin
        cnt_next = cnt_inc;
        if (valid) begin
          rdata_next[15:0] = rd_data;
          rden_next        = 1'b0;
          state_next       = RD_W1;
        end else if (timeout_hit) begin
          rden_next      = 1'b0;
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end
      end
      RD_W1: begin
        cnt_next = cnt_inc;
        if (valid) begin
          rdata_next[31:16] = rd_data;
          state_next        = RESP;
          rsp_valid_next    = 1'b1;
        end else if (timeout_hit) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end
      end
      WR_REQ: begin
        cnt_next = cnt_inc;
        if (fetch) begin
          wren_next  = 1'b0;
          state_next = WR_P1;
        end else if (timeout_hit) begin
          wren_next      = 1'b0;
          wr_data_next   = 16'd0;
          wr_bena_next   = 2'd0;
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end
      end
      WR_P1: begin
        state_next = WR_P2;
      end
      WR_P2: begin
        // Write data stays on the bus through p2, then is released.
        wr_data_next   = 16'd0;
        wr_bena_next   = 2'd0;
        state_next     = RESP;
        rsp_valid_next = 1'b1;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= 10'd0;
      rden_reg      <= 1'b0;
      wren_reg      <= 1'b0;
      addr_reg      <= 32'd0;
      rdata_reg     <= 32'd0;
      wr_data_reg   <= 16'd0;
      wr_bena_reg   <= 2'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      rden_reg      <= rden_next;
      wren_reg      <= wren_next;
      addr_reg      <= addr_next;
      rdata_reg     <= rdata_next;
      wr_data_reg   <= wr_data_next;
      wr_bena_reg   <= wr_bena_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign rden      = rden_reg;
  assign wren      = wren_reg;
  assign addr      = addr_reg;
  assign rsp_rdata = rdata_reg;
  assign wr_data   = wr_data_reg;
  assign wr_bena   = wr_bena_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_sdram_bank_client.sv
// Randomized bench for sdram_bank_client: plays the SDRAM controller and checks
// every cycle against latencies derived from the transaction rules.
module tb_sdram_bank_client;

  localparam int         T    = 8;
  localparam logic [1:0] BANK = 2'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_rdy_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [1:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rden;
  logic        wren;
  logic [31:0] addr;
  logic        valid;
  logic        fetch;
  logic [1:0]  wr_bena;
  logic [15:0] wr_data;
  logic [15:0] rd_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          txn_id  = 0;
  logic [31:0] rdata_model = 32'd0;

  sdram_bank_client #(.TIMEOUT(T), .BANK_SEL(BANK)) dut (
    .clk(clk), .rst(rst), .ram_rdy_n(ram_rdy_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rden(rden), .wren(wren), .addr(addr), .valid(valid), .fetch(fetch),
    .wr_bena(wr_bena), .wr_data(wr_data), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction. d1 = cycle (from entering the request state) of the first
  // valid / the fetch; d2 = idle cycles between the two read valids.
  task automatic do_txn(input bit we, input logic [23:0] a, input logic [15:0] wd,
                        input logic [1:0] be, input int d1, input int d2,
                        input logic [15:0] v1, input logic [15:0] v2,
                        input bit hold, output int waited);
    int          exp_k, last_req, k2, tcyc;
    bit          err;
    logic [31:0] exp_addr, new_rdata;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd; cmd_be = be;
    waited = 0;
    #1;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    check_eq("accept_ready", 32'(cmd_ready), 32'd1);

    new_rdata = rdata_model;
    k2 = d1 + 1 + d2;
    if (we) exp_addr = (32'(BANK) << 24) | 32'(a & 24'hFFFFFE);
    else    exp_addr = (32'(BANK) << 24) | 32'(a & 24'hFFFFFC);
    if (d1 >= T) begin
      err = 1'b1; exp_k = T; last_req = T - 1;
    end else if (we) begin
      err = 1'b0; exp_k = d1 + 3; last_req = d1;
    end else begin
      last_req = d1;
      new_rdata[15:0] = v1;
      tcyc = (d1 + 1 > T - 1) ? d1 + 1 : T - 1;
      if (k2 > tcyc) begin
        err = 1'b1; exp_k = tcyc + 1;
      end else begin
        err = 1'b0; exp_k = k2 + 1; new_rdata[31:16] = v2;
      end
    end

    @(negedge clk);
    for (int k = 0; k <= exp_k; k++) begin
      if (!hold) cmd_valid = 1'b0;
      ram_rdy_n = (k > 0 && k < exp_k) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (we) begin
        fetch   = (k == d1 && k < exp_k) || k == exp_k;
        valid   = 1'($urandom_range(0, 1));
        rd_data = 16'($urandom);
      end else begin
        valid   = (k < exp_k && (k == d1 || k == k2)) || k == exp_k;
        fetch   = 1'($urandom_range(0, 1));
        rd_data = (k == d1) ? v1 : (k == k2) ? v2 : 16'($urandom);
      end
      #1;
      check_eq("rden", 32'(rden), 32'(!we && k <= last_req));
      check_eq("wren", 32'(wren), 32'(we && k <= last_req));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(k == exp_k));
      check_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      check_eq("wr_data", 32'(wr_data), (we && k < exp_k) ? 32'(wd) : 32'd0);
      check_eq("wr_bena", 32'(wr_bena), (we && k < exp_k) ? 32'(be) : 32'd0);
      if (k == 0) check_eq("addr", addr, exp_addr);
      if (k == exp_k) begin
        check_eq("rsp_err", 32'(rsp_err), 32'(err));
        check_eq("rsp_rdata", rsp_rdata, new_rdata);
      end
      @(negedge clk);
    end
    valid = 1'b0; fetch = 1'b0; ram_rdy_n = 1'b0;
    rdata_model = new_rdata;
    #1;
    check_eq("idle_rden", 32'(rden), 32'd0);
    check_eq("idle_ready", 32'(cmd_ready), 32'd1);
    txn_id++;
    $display("[TB] txn %0d %s addr=%h d1=%0d d2=%0d err=%0d rdata=%h", txn_id,
             we ? "WR" : "RD", a, d1, d2, err, new_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; ram_rdy_n = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = 24'd0; cmd_wdata = 16'd0; cmd_be = 2'd0;
    valid = 1'b0; fetch = 1'b0; rd_data = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_outs", {26'd0, rden, wren, rsp_valid, rsp_err, wr_bena}, 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd0);

    // Controller not ready: request must be held off.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h001236;
    repeat (4) begin
      @(negedge clk); #1;
      check_eq("nr_ready", 32'(cmd_ready), 32'd0);
      check_eq("nr_rden", 32'(rden), 32'd0);
    end
    ram_rdy_n = 1'b0;
    do_txn(1'b0, 24'h001236, 16'd0, 2'd0, 0, 1, 16'hAAAA, 16'h5555, 1'b0, w);
    check_eq("nr_wait", 32'(w), 32'd0);
    check_eq("read_rdata", rsp_rdata, 32'h5555_AAAA);

    do_txn(1'b1, 24'h000010, 16'hBEEF, 2'b10, 2, 0, 16'd0, 16'd0, 1'b0, w);
    do_txn(1'b0, 24'h0000A0, 16'd0, 2'd0, 20, 0, 16'h1111, 16'h2222, 1'b0, w);
    do_txn(1'b0, 24'h0000A4, 16'd0, 2'd0, T - 1, 0, 16'h3333, 16'h4444, 1'b0, w);
    do_txn(1'b0, 24'h0000A8, 16'd0, 2'd0, T - 1, 1, 16'h5151, 16'h6262, 1'b0, w);
    do_txn(1'b0, 24'h0000AC, 16'd0, 2'd0, 2, 10, 16'h7777, 16'h8888, 1'b0, w);
    do_txn(1'b1, 24'h000100, 16'h1234, 2'b01, 20, 0, 16'd0, 16'd0, 1'b0, w);
    do_txn(1'b1, 24'h000102, 16'h5678, 2'b11, T - 1, 0, 16'd0, 16'd0, 1'b0, w);

    // Back-to-back reads with cmd_valid held high.
    do_txn(1'b0, 24'h000200, 16'd0, 2'd0, 1, 0, 16'hC0DE, 16'hF00D, 1'b1, w);
    do_txn(1'b0, 24'h000204, 16'd0, 2'd0, 0, 2, 16'hCAFE, 16'hBABE, 1'b0, w);
    check_eq("b2b_wait", 32'(w), 32'd0);

    // Reset in RD_W1 discards the read; later valids are ignored.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h00ABCD;
    #1;
    check_eq("mr_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; valid = 1'b1; rd_data = 16'h1357;
    @(negedge clk);
    valid = 1'b0; rst = 1'b1;
    #1;
    check_eq("mr_w1_rden", 32'(rden), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mr_addr", addr, 32'd0);
    check_eq("mr_rdata", rsp_rdata, 32'd0);
    check_eq("mr_outs", {26'd0, rden, wren, rsp_valid, rsp_err, wr_bena}, 32'd0);
    check_eq("mr_ready_idle", 32'(cmd_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      valid = 1'b1; rd_data = 16'($urandom);
      #1;
      check_eq("mr_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("mr_no_rden", 32'(rden), 32'd0);
      check_eq("mr_rdata_hold", rsp_rdata, 32'd0);
    end
    @(negedge clk);
    valid = 1'b0;
    rdata_model = 32'd0;

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom),
             2'($urandom), $urandom_range(0, 10), $urandom_range(0, 3),
             16'($urandom), 16'($urandom), 1'b0, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
